// File: rtl/ctrl_pipe_shift.sv
// Control-word pipeline from ID through STAGES registers (stage 0 = EX, last = WB).
// Handles bubble insertion, per-stage flush, global hold, and saturating retire/bubble counters.
module ctrl_pipe_shift #(
   parameter int CTRL_W = 16,
   parameter int STAGES = 3,
   parameter int CNT_W  = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [CTRL_W-1:0]          id_ctrl_i,
   input  logic                       id_valid_i,
   input  logic                       stall_i,
   input  logic [STAGES-1:0]          flush_mask_i,
   input  logic                       hold_i,
   input  logic                       clear_counts_i,
   output logic [STAGES*CTRL_W-1:0]   stage_ctrl_o,
   output logic [STAGES-1:0]          stage_valid_o,
   output logic [CTRL_W-1:0]          wb_ctrl_o,
   output logic                       retire_pulse_o,
   output logic [CNT_W-1:0]           retired_count_o,
   output logic [CNT_W-1:0]           bubble_count_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [STAGES-1:0] valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q [STAGES];
   logic [CTRL_W-1:0] ctrl_d [STAGES];
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic [CNT_W-1:0]  bubble_q, bubble_d;
   logic              s0_valid_in;
   logic              retire;

   assign s0_valid_in = id_valid_i & ~stall_i & ~flush_mask_i[0];
   assign retire      = valid_q[STAGES-1] & ~hold_i;

   // Invalid entries are always written as zero so a bubble never carries RegWr/MemWr.
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < STAGES; i++) begin
         ctrl_d[i] = ctrl_q[i];
      end
      if (!hold_i) begin
         valid_d[0] = s0_valid_in;
         ctrl_d[0]  = s0_valid_in ? id_ctrl_i : '0;
         for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1] & ~flush_mask_i[i];
            ctrl_d[i]  = (valid_q[i-1] & ~flush_mask_i[i]) ? ctrl_q[i-1] : '0;
         end
      end
   end

   // Clear wins over hold and over increments.
   always_comb begin
      retired_d = retired_q;
      bubble_d  = bubble_q;
      if (clear_counts_i) begin
         retired_d = '0;
         bubble_d  = '0;
      end else if (!hold_i) begin
         if (retire && (retired_q != CNT_MAX)) begin
            retired_d = retired_q + CNT_W'(1);
         end
         if (!s0_valid_in && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q   <= '0;
         retired_q <= '0;
         bubble_q  <= '0;
         for (int i = 0; i < STAGES; i++) begin
            ctrl_q[i] <= '0;
         end
      end else begin
         valid_q   <= valid_d;
         retired_q <= retired_d;
         bubble_q  <= bubble_d;
         for (int i = 0; i < STAGES; i++) begin
            ctrl_q[i] <= ctrl_d[i];
         end
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_out
      assign stage_ctrl_o[g*CTRL_W +: CTRL_W] = ctrl_q[g];
   end

   assign stage_valid_o   = valid_q;
   assign wb_ctrl_o       = ctrl_q[STAGES-1];
   assign retire_pulse_o  = retire;
   assign retired_count_o = retired_q;
   assign bubble_count_o  = bubble_q;

endmodule

// File: tb/tb_ctrl_pipe_shift.sv
// Bench for ctrl_pipe_shift: directed vector table, hand-written corner sequences,
// and randomized traffic against a list-of-entries reference model.
module tb_ctrl_pipe_shift;

   localparam int CTRL_W = 16;
   localparam int STAGES = 3;

   logic                     clk;
   logic                     reset;
   logic [CTRL_W-1:0]        id_ctrl;
   logic                     id_valid;
   logic                     stall;
   logic [STAGES-1:0]        flush_mask;
   logic                     hold;
   logic                     clear_counts;

   logic [STAGES*CTRL_W-1:0] stage_ctrl, s_stage_ctrl;
   logic [STAGES-1:0]        stage_valid, s_stage_valid;
   logic [CTRL_W-1:0]        wb_ctrl, s_wb_ctrl;
   logic                     retire_pulse, s_retire_pulse;
   logic [15:0]              retired_count, bubble_count;
   logic [3:0]               s_retired_count, s_bubble_count;

   int checks = 0;
   int errors = 0;

   ctrl_pipe_shift #(.CTRL_W(CTRL_W), .STAGES(STAGES), .CNT_W(16)) dut (
      .clk_i(clk), .reset_i(reset), .id_ctrl_i(id_ctrl), .id_valid_i(id_valid),
      .stall_i(stall), .flush_mask_i(flush_mask), .hold_i(hold),
      .clear_counts_i(clear_counts), .stage_ctrl_o(stage_ctrl),
      .stage_valid_o(stage_valid), .wb_ctrl_o(wb_ctrl),
      .retire_pulse_o(retire_pulse), .retired_count_o(retired_count),
      .bubble_count_o(bubble_count)
   );

   ctrl_pipe_shift #(.CTRL_W(CTRL_W), .STAGES(STAGES), .CNT_W(4)) dut_small (
      .clk_i(clk), .reset_i(reset), .id_ctrl_i(id_ctrl), .id_valid_i(id_valid),
      .stall_i(stall), .flush_mask_i(flush_mask), .hold_i(hold),
      .clear_counts_i(clear_counts), .stage_ctrl_o(s_stage_ctrl),
      .stage_valid_o(s_stage_valid), .wb_ctrl_o(s_wb_ctrl),
      .retire_pulse_o(s_retire_pulse), .retired_count_o(s_retired_count),
      .bubble_count_o(s_bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Reference model: list of in-flight entries plus true (unbounded) event counts.
   typedef struct {
      logic              v;
      logic [CTRL_W-1:0] c;
   } ent_t;

   ent_t pipe [STAGES];
   int   m_ret;
   int   m_bub;

   typedef struct {
      logic [CTRL_W-1:0] id;
      logic              v;
      logic              st;
      logic [STAGES-1:0] fl;
      logic              hd;
      logic [STAGES-1:0] e_valid;
      logic [CTRL_W-1:0] e_s0;
      logic [CTRL_W-1:0] e_wb;
      int                e_ret;
      int                e_bub;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int sat(input int raw, input int maxv);
      return (raw > maxv) ? maxv : raw;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < STAGES; i++) begin
         pipe[i].v = 1'b0;
         pipe[i].c = '0;
      end
      m_ret = 0;
      m_bub = 0;
   endtask

   task automatic check_model();
      logic [STAGES*CTRL_W-1:0] ec;
      logic [STAGES-1:0]        ev;
      for (int i = 0; i < STAGES; i++) begin
         ev[i] = pipe[i].v;
         ec[i*CTRL_W +: CTRL_W] = pipe[i].c;
      end
      chk("stage_valid", 64'(stage_valid), 64'(ev));
      chk("stage_ctrl", 64'(stage_ctrl), 64'(ec));
      chk("wb_ctrl", 64'(wb_ctrl), 64'(pipe[STAGES-1].c));
      chk("retired_count", 64'(retired_count), 64'(sat(m_ret, 65535)));
      chk("bubble_count", 64'(bubble_count), 64'(sat(m_bub, 65535)));
      chk("small_stage_ctrl", 64'(s_stage_ctrl), 64'(ec));
      chk("small_retired", 64'(s_retired_count), 64'(sat(m_ret, 15)));
      chk("small_bubble", 64'(s_bubble_count), 64'(sat(m_bub, 15)));
   endtask

   // Inputs must be set by the caller before calling; they stay fixed across the edge.
   task automatic tick();
      logic rp;
      logic s0v;
      ent_t nxt [STAGES];
      #1;
      rp = reset ? 1'b0 : (pipe[STAGES-1].v & ~hold);
      chk("retire_pulse", 64'(retire_pulse), 64'(rp));
      s0v = id_valid & ~stall & ~flush_mask[0];
      @(posedge clk);
      #1;
      if (reset) begin
         model_reset();
      end else begin
         if (clear_counts) begin
            m_ret = 0;
            m_bub = 0;
         end else if (!hold) begin
            if (rp) m_ret++;
            if (!s0v) m_bub++;
         end
         if (!hold) begin
            nxt[0].v = s0v;
            nxt[0].c = s0v ? id_ctrl : '0;
            for (int i = 1; i < STAGES; i++) begin
               nxt[i].v = pipe[i-1].v & ~flush_mask[i];
               nxt[i].c = nxt[i].v ? pipe[i-1].c : '0;
            end
            pipe = nxt;
         end
      end
      check_model();
   endtask

   task automatic set_in(input logic [CTRL_W-1:0] c, input logic v, input logic st,
                         input logic [STAGES-1:0] fl, input logic hd, input logic clr);
      id_ctrl = c; id_valid = v; stall = st; flush_mask = fl; hold = hd; clear_counts = clr;
   endtask

   initial begin
      // id, v, stall, flush, hold | exp valid, exp stage0, exp wb, exp retired, exp bubbles
      tbl[0]  = '{16'h0001, 1'b1, 1'b0, 3'b000, 1'b0, 3'b001, 16'h0001, 16'h0000, 0, 0};
      tbl[1]  = '{16'h0002, 1'b1, 1'b0, 3'b000, 1'b0, 3'b011, 16'h0002, 16'h0000, 0, 0};
      tbl[2]  = '{16'h0003, 1'b1, 1'b0, 3'b000, 1'b0, 3'b111, 16'h0003, 16'h0001, 0, 0};
      tbl[3]  = '{16'h00F0, 1'b1, 1'b1, 3'b000, 1'b0, 3'b110, 16'h0000, 16'h0002, 1, 1};
      tbl[4]  = '{16'h00F0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b101, 16'h00F0, 16'h0003, 2, 1};
      tbl[5]  = '{16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b010, 16'h0000, 16'h0000, 3, 2};
      tbl[6]  = '{16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b100, 16'h0000, 16'h00F0, 3, 3};
      tbl[7]  = '{16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 16'h0000, 16'h0000, 4, 4};
      tbl[8]  = '{16'h0011, 1'b1, 1'b0, 3'b000, 1'b0, 3'b001, 16'h0011, 16'h0000, 4, 4};
      tbl[9]  = '{16'h0022, 1'b1, 1'b0, 3'b000, 1'b0, 3'b011, 16'h0022, 16'h0000, 4, 4};
      tbl[10] = '{16'h0033, 1'b1, 1'b0, 3'b000, 1'b0, 3'b111, 16'h0033, 16'h0011, 4, 4};
      tbl[11] = '{16'h0044, 1'b1, 1'b0, 3'b011, 1'b0, 3'b100, 16'h0000, 16'h0022, 5, 5};
      tbl[12] = '{16'h0000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 16'h0000, 16'h0000, 6, 6};

      reset = 1'b1;
      set_in('0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_valid", 64'(stage_valid), 64'h0);
      chk("reset_ctrl", 64'(stage_ctrl), 64'h0);
      chk("reset_counts", 64'({retired_count, bubble_count}), 64'h0);

      for (int r = 0; r < 13; r++) begin
         set_in(tbl[r].id, tbl[r].v, tbl[r].st, tbl[r].fl, tbl[r].hd, 1'b0);
         tick();
         chk($sformatf("tbl%0d_valid", r), 64'(stage_valid), 64'(tbl[r].e_valid));
         chk($sformatf("tbl%0d_s0", r), 64'(stage_ctrl[CTRL_W-1:0]), 64'(tbl[r].e_s0));
         chk($sformatf("tbl%0d_wb", r), 64'(wb_ctrl), 64'(tbl[r].e_wb));
         chk($sformatf("tbl%0d_ret", r), 64'(retired_count), 64'(tbl[r].e_ret));
         chk($sformatf("tbl%0d_bub", r), 64'(bubble_count), 64'(tbl[r].e_bub));
      end

      // Hold with a full pipeline; stall/flush/id noise must be ignored.
      set_in(16'h0101, 1'b1, 1'b0, '0, 1'b0, 1'b0); tick();
      set_in(16'h0202, 1'b1, 1'b0, '0, 1'b0, 1'b0); tick();
      set_in(16'h0303, 1'b1, 1'b0, '0, 1'b0, 1'b0); tick();
      for (int k = 0; k < 4; k++) begin
         set_in(16'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'b1, 1'b0);
         tick();
         chk("hold_valid", 64'(stage_valid), 64'h7);
         chk("hold_wb", 64'(wb_ctrl), 64'h0101);
         chk("hold_counts", 64'({retired_count, bubble_count}), 64'h0006_0006);
         chk("hold_rp", 64'(retire_pulse), 64'h0);
      end
      set_in('0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
      chk("post_hold_wb", 64'(wb_ctrl), 64'h0202);
      chk("post_hold_ret", 64'(retired_count), 64'h7);

      // Asynchronous reset in the middle of A5A5 traffic.
      set_in(16'hA5A5, 1'b1, 1'b0, '0, 1'b0, 1'b0); tick(); tick();
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 64'(stage_valid), 64'h0);
      chk("async_rst_ctrl", 64'(stage_ctrl), 64'h0);
      chk("async_rst_wb", 64'(wb_ctrl), 64'h0);
      chk("async_rst_counts", 64'({retired_count, bubble_count}), 64'h0);
      chk("async_rst_rp", 64'(retire_pulse), 64'h0);
      model_reset();
      tick();
      reset = 1'b0;
      tick(); tick();
      chk("rst_release_wb2", 64'(wb_ctrl), 64'h0);
      tick();
      chk("rst_release_wb3", 64'(wb_ctrl), 64'hA5A5);

      // Saturation on the 4-bit counter instance, then clear while held.
      reset = 1'b1; #1; model_reset(); tick(); reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         set_in(16'(k + 1), 1'b1, 1'b0, '0, 1'b0, 1'b0);
         tick();
      end
      set_in('0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      repeat (5) tick();
      chk("sat_small_ret", 64'(s_retired_count), 64'd15);
      chk("sat_main_ret", 64'(retired_count), 64'd20);
      chk("sat_small_bub", 64'(s_bubble_count), 64'd5);
      set_in('0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
      tick();
      chk("clear_in_hold", 64'({retired_count, bubble_count, 8'(s_retired_count)}), 64'h0);
      set_in('0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         reset = ($urandom_range(0, 99) == 0);
         set_in(16'($urandom),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) == 0),
                {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0)},
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 31) == 0));
         tick();
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
